sys_ctrl_burst: RTL and testbench

Parametrised command controller in the REF_CLK domain, between the RX data synchroniser, register file, gated ALU and TX async FIFO. It decodes byte-framed commands, drives register-file reads and writes and ALU operations, and serialises results into the TX FIFO under FIFO_FULL backpressure. It generalises the current single-byte controller in three ways: width/address parameters, multi-byte ALU result serialisation, and optional burst register access.

---
 rtl/sys_ctrl_pkg.sv | 28 ++
 rtl/sys_ctrl_tx_ser.sv | 45 ++++
 rtl/sys_ctrl_burst.sv | 212 +++++++++++++++++++++
 tb/tb_sys_ctrl_burst.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: opcode constants, FSM state and operation enums, and the
// fixed operand addresses used by the sys_ctrl_burst command controller.
// The BCNT/BDATA states only exist when SYS_CTRL_BURST_CMD_EN is defined.
package sys_ctrl_pkg;

  localparam logic [7:0] OPC_WR      = 8'hAA;
  localparam logic [7:0] OPC_RD      = 8'hBB;
  localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
  localparam logic [7:0] OPC_ALU_NOP = 8'hDD;
  localparam logic [7:0] OPC_BWR     = 8'hEE;
  localparam logic [7:0] OPC_BRD     = 8'hEF;

  // Register-file slots that receive the ALU operands A and B
  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, WDATA, OPA, OPB, FUN,
`ifdef SYS_CTRL_BURST_CMD_EN
    BCNT, BDATA,
`endif
    RD_WAIT, ALU_WAIT, TX
  } state_t;

  // Kind of frame in progress, remembered from the opcode byte
  typedef enum logic [1:0] {OP_WR, OP_RD, OP_BWR, OP_BRD} op_t;

endpackage

// File: rtl/sys_ctrl_tx_ser.sv
// sys_ctrl_tx_ser: latches a 1- or 2-byte result word and pushes it into the
// TX FIFO least-significant byte first, holding the current byte while the
// FIFO reports full so nothing is lost or repeated.
module sys_ctrl_tx_ser #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic                      two,
  input  logic [2*DATA_WIDTH-1:0]   word,
  input  logic                      fifo_full,
  output logic [DATA_WIDTH-1:0]     tx_data,
  output logic                      tx_vld,
  output logic                      done
);

  logic [2*DATA_WIDTH-1:0] word_q;
  logic                    busy_q;
  logic                    idx_q;
  logic                    two_q;

  assign tx_data = idx_q ? word_q[2*DATA_WIDTH-1:DATA_WIDTH] : word_q[DATA_WIDTH-1:0];
  assign tx_vld  = busy_q && !fifo_full;
  assign done    = tx_vld && (idx_q == two_q);

  // Load a new word, or advance one byte each time the FIFO accepts one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      busy_q <= 1'b0;
      idx_q  <= 1'b0;
      two_q  <= 1'b0;
    end else if (load) begin
      word_q <= word;
      two_q  <= two;
      idx_q  <= 1'b0;
      busy_q <= 1'b1;
    end else if (tx_vld) begin
      if (done) busy_q <= 1'b0;
      else      idx_q  <= 1'b1;
    end
  end

endmodule

// File: rtl/sys_ctrl_burst.sv
// sys_ctrl_burst: byte-framed command controller. Decodes write, read and ALU
// frames, drives the register file and ALU, and returns results through the
// TX serialiser. Optional burst write/read (0xEE/0xEF) is enabled with the
// SYS_CTRL_BURST_CMD_EN macro; without it those opcodes are unknown.
module sys_ctrl_burst
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_DATA,
  input  logic                    RX_VLD,
  input  logic [DATA_WIDTH-1:0]   RF_RdData,
  input  logic                    RF_RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_Valid,
  input  logic                    FIFO_FULL,
  output logic [ADDR_WIDTH-1:0]   RF_Address,
  output logic                    RF_WrEn,
  output logic                    RF_RdEn,
  output logic [DATA_WIDTH-1:0]   RF_WrData,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    CLKG_EN,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_VLD,
  output logic                    CLKDIV_EN,
  output logic                    CMD_ERR
);

  state_t                  state_q, state_n;
  op_t                     op_q, op_n;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_n, rf_addr_n;
  logic [DATA_WIDTH-1:0]   wr_data_n;
  logic [FUN_WIDTH-1:0]    fun_n;
  logic                    wr_en_n, rd_en_n, alu_en_n, clkg_n, err_n;
  logic                    ser_load, ser_two, ser_done;
  logic [2*DATA_WIDTH-1:0] ser_word;
`ifdef SYS_CTRL_BURST_CMD_EN
  logic [DATA_WIDTH-1:0]   cnt_q, cnt_n;
`endif

  // Next-state and next-output decode; strobes default low, held fields keep value
  always_comb begin
    state_n   = state_q;
    op_n      = op_q;
    addr_n    = addr_q;
    rf_addr_n = RF_Address;
    wr_data_n = RF_WrData;
    fun_n     = ALU_FUN;
    clkg_n    = CLKG_EN;
    wr_en_n   = 1'b0;
    rd_en_n   = 1'b0;
    alu_en_n  = 1'b0;
    err_n     = RX_VLD && (state_q == RD_WAIT || state_q == ALU_WAIT || state_q == TX);
    ser_load  = 1'b0;
    ser_two   = 1'b0;
    ser_word  = {{DATA_WIDTH{1'b0}}, RF_RdData};
`ifdef SYS_CTRL_BURST_CMD_EN
    cnt_n     = cnt_q;
`endif
    case (state_q)
      IDLE: if (RX_VLD) begin
        case (RX_DATA)
          DATA_WIDTH'(OPC_WR):      begin op_n = OP_WR; state_n = ADDR; end
          DATA_WIDTH'(OPC_RD):      begin op_n = OP_RD; state_n = ADDR; end
          DATA_WIDTH'(OPC_ALU_OP):  state_n = OPA;
          DATA_WIDTH'(OPC_ALU_NOP): state_n = FUN;
`ifdef SYS_CTRL_BURST_CMD_EN
          DATA_WIDTH'(OPC_BWR):     begin op_n = OP_BWR; state_n = ADDR; end
          DATA_WIDTH'(OPC_BRD):     begin op_n = OP_BRD; state_n = ADDR; end
`endif
          default:                  err_n = 1'b1;
        endcase
      end
      ADDR: if (RX_VLD) begin
        addr_n = RX_DATA[ADDR_WIDTH-1:0];
        if (op_q == OP_RD) begin
          rd_en_n   = 1'b1;
          rf_addr_n = RX_DATA[ADDR_WIDTH-1:0];
          state_n   = RD_WAIT;
        end
`ifdef SYS_CTRL_BURST_CMD_EN
        else if (op_q == OP_BWR || op_q == OP_BRD) state_n = BCNT;
`endif
        else state_n = WDATA;
      end
      WDATA: if (RX_VLD) begin
        wr_en_n   = 1'b1;
        rf_addr_n = addr_q;
        wr_data_n = RX_DATA;
        state_n   = IDLE;
      end
      OPA: if (RX_VLD) begin
        wr_en_n   = 1'b1;
        rf_addr_n = ADDR_WIDTH'(OPA_ADDR);
        wr_data_n = RX_DATA;
        state_n   = OPB;
      end
      OPB: if (RX_VLD) begin
        wr_en_n   = 1'b1;
        rf_addr_n = ADDR_WIDTH'(OPB_ADDR);
        wr_data_n = RX_DATA;
        state_n   = FUN;
      end
      FUN: if (RX_VLD) begin
        fun_n    = RX_DATA[FUN_WIDTH-1:0];
        alu_en_n = 1'b1;
        clkg_n   = 1'b1;
        state_n  = ALU_WAIT;
      end
`ifdef SYS_CTRL_BURST_CMD_EN
      BCNT: if (RX_VLD) begin
        cnt_n = RX_DATA;
        if (RX_DATA == '0) state_n = IDLE;
        else if (op_q == OP_BWR) state_n = BDATA;
        else begin
          rd_en_n   = 1'b1;
          rf_addr_n = addr_q;
          state_n   = RD_WAIT;
        end
      end
      BDATA: if (RX_VLD) begin
        wr_en_n   = 1'b1;
        rf_addr_n = addr_q;
        wr_data_n = RX_DATA;
        addr_n    = addr_q + 1'b1;
        cnt_n     = cnt_q - 1'b1;
        if (cnt_q == DATA_WIDTH'(1)) state_n = IDLE;
      end
`endif
      RD_WAIT: if (RF_RdData_Valid) begin
        ser_load = 1'b1;
        state_n  = TX;
      end
      ALU_WAIT: if (ALU_OUT_Valid) begin
        clkg_n   = 1'b0;
        ser_load = 1'b1;
        ser_two  = 1'b1;
        ser_word = ALU_OUT;
        state_n  = TX;
      end
      TX: if (ser_done) begin
        state_n = IDLE;
`ifdef SYS_CTRL_BURST_CMD_EN
        // A burst read fetches the next register only after the previous byte left
        if (op_q == OP_BRD && cnt_q != DATA_WIDTH'(1)) begin
          cnt_n     = cnt_q - 1'b1;
          addr_n    = addr_q + 1'b1;
          rf_addr_n = addr_q + 1'b1;
          rd_en_n   = 1'b1;
          state_n   = RD_WAIT;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any frame in progress
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      op_q       <= OP_WR;
      addr_q     <= '0;
      RF_Address <= '0;
      RF_WrData  <= '0;
      RF_WrEn    <= 1'b0;
      RF_RdEn    <= 1'b0;
      ALU_EN     <= 1'b0;
      ALU_FUN    <= '0;
      CLKG_EN    <= 1'b0;
      CMD_ERR    <= 1'b0;
      CLKDIV_EN  <= 1'b0;
`ifdef SYS_CTRL_BURST_CMD_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_n;
      op_q       <= op_n;
      addr_q     <= addr_n;
      RF_Address <= rf_addr_n;
      RF_WrData  <= wr_data_n;
      RF_WrEn    <= wr_en_n;
      RF_RdEn    <= rd_en_n;
      ALU_EN     <= alu_en_n;
      ALU_FUN    <= fun_n;
      CLKG_EN    <= clkg_n;
      CMD_ERR    <= err_n;
      CLKDIV_EN  <= 1'b1;
`ifdef SYS_CTRL_BURST_CMD_EN
      cnt_q      <= cnt_n;
`endif
    end
  end

  sys_ctrl_tx_ser #(.DATA_WIDTH(DATA_WIDTH)) u_tx_ser (
    .clk       (CLK),
    .rst_n     (RST),
    .load      (ser_load),
    .two       (ser_two),
    .word      (ser_word),
    .fifo_full (FIFO_FULL),
    .tx_data   (TX_DATA),
    .tx_vld    (TX_VLD),
    .done      (ser_done)
  );

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// tb_sys_ctrl_burst: self-checking bench for sys_ctrl_burst. Frames are
// turned into expected register writes, reads, ALU starts, TX bytes and error
// pulses by a transaction-level model; a monitor collects what the DUT does.
// Burst cases follow the SYS_CTRL_BURST_CMD_EN macro.
module tb_sys_ctrl_burst;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_DATA = '0;
  logic        RX_VLD = 1'b0;
  logic [7:0]  RF_RdData;
  logic        RF_RdData_Valid;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_Valid;
  logic        FIFO_FULL;
  logic [3:0]  RF_Address;
  logic        RF_WrEn, RF_RdEn, ALU_EN, CLKG_EN, TX_VLD, CLKDIV_EN, CMD_ERR;
  logic [7:0]  RF_WrData, TX_DATA;
  logic [3:0]  ALU_FUN;

  sys_ctrl_burst #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VLD(RX_VLD),
    .RF_RdData(RF_RdData), .RF_RdData_Valid(RF_RdData_Valid),
    .ALU_OUT(ALU_OUT), .ALU_OUT_Valid(ALU_OUT_Valid), .FIFO_FULL(FIFO_FULL),
    .RF_Address(RF_Address), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
    .RF_WrData(RF_WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .CLKG_EN(CLKG_EN), .TX_DATA(TX_DATA), .TX_VLD(TX_VLD),
    .CLKDIV_EN(CLKDIV_EN), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Responder tables and environment knobs
  logic [7:0]  rd_tab [16];
  logic [15:0] alu_tab [16];
  bit          force_full = 1'b0;
  bit          bp_rand    = 1'b0;
  bit          alu_hold   = 1'b0;

  // Observed and expected transaction lists
  int wr_q[$], rd_q[$], tx_q[$], fun_q[$];
  int exp_wr[$], exp_rd[$], exp_tx[$], exp_fun[$];
  int err_cnt = 0, exp_err = 0, full_viol = 0;
  logic [7:0] frame[$];

  // Monitor: record every strobe away from the active edge
  always @(negedge CLK) begin
    if (RST) begin
      if (RF_WrEn) wr_q.push_back(int'(RF_Address) * 256 + int'(RF_WrData));
      if (RF_RdEn) rd_q.push_back(int'(RF_Address));
      if (ALU_EN)  fun_q.push_back(int'(ALU_FUN));
      if (TX_VLD)  tx_q.push_back(int'(TX_DATA));
      if (TX_VLD && FIFO_FULL) full_viol++;
      if (CMD_ERR) err_cnt++;
    end
  end

  // Register-file read responder: data 1..4 cycles after RF_RdEn
  int rd_wait = 0;
  logic [3:0] rd_addr = '0;
  initial begin
    RF_RdData_Valid = 1'b0;
    RF_RdData = '0;
    forever begin
      @(posedge CLK); #1;
      RF_RdData_Valid = 1'b0;
      if (rd_wait > 0) begin
        rd_wait--;
        if (rd_wait == 0) begin
          RF_RdData_Valid = 1'b1;
          RF_RdData = rd_tab[rd_addr];
        end
      end
      if (RF_RdEn) begin
        rd_addr = RF_Address;
        rd_wait = $urandom_range(1, 4);
      end
    end
  end

  // ALU responder: result 1..4 cycles after ALU_EN, can be held off
  int alu_wait = 0;
  logic [3:0] alu_fun = '0;
  initial begin
    ALU_OUT_Valid = 1'b0;
    ALU_OUT = '0;
    forever begin
      @(posedge CLK); #1;
      ALU_OUT_Valid = 1'b0;
      if (alu_wait > 1) alu_wait--;
      else if (alu_wait == 1 && !alu_hold) begin
        alu_wait = 0;
        ALU_OUT_Valid = 1'b1;
        ALU_OUT = alu_tab[alu_fun];
      end
      if (ALU_EN) begin
        alu_fun = ALU_FUN;
        alu_wait = $urandom_range(1, 4);
      end
    end
  end

  // TX FIFO full: directed hold or random backpressure
  initial begin
    FIFO_FULL = 1'b0;
    forever begin
      @(posedge CLK); #1;
      FIFO_FULL = bp_rand ? ($urandom_range(0, 2) == 0) : force_full;
    end
  end

  task automatic send_frame(input int gap_max);
    int g;
    while (frame.size() > 0) begin
      @(posedge CLK); #1;
      RX_DATA = frame.pop_front();
      RX_VLD = 1'b1;
      g = $urandom_range(0, gap_max);
      if (g > 0) begin
        @(posedge CLK); #1;
        RX_VLD = 1'b0;
        repeat (g - 1) @(posedge CLK);
      end
    end
    @(posedge CLK); #1;
    RX_VLD = 1'b0;
  endtask

  task automatic wait_done();
    int budget = 400;
    while (tx_q.size() < exp_tx.size() && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    repeat (4) @(negedge CLK);
  endtask

  task automatic cmp_list(input string tag, input int got[$], input int exp[$]);
    int n;
    check_eq({tag, " count"}, got.size(), exp.size());
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  task automatic compare_all(input string tag);
    cmp_list({tag, " wr"}, wr_q, exp_wr);
    cmp_list({tag, " rd"}, rd_q, exp_rd);
    cmp_list({tag, " fun"}, fun_q, exp_fun);
    cmp_list({tag, " tx"}, tx_q, exp_tx);
    check_eq({tag, " cmd_err"}, err_cnt, exp_err);
    wr_q.delete(); rd_q.delete(); fun_q.delete(); tx_q.delete();
    exp_wr.delete(); exp_rd.delete(); exp_fun.delete(); exp_tx.delete();
    err_cnt = 0; exp_err = 0;
  endtask

  // Reference model: frames expressed as the accesses they must cause
  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    frame.push_back(8'hAA); frame.push_back(a); frame.push_back(d);
    exp_wr.push_back((a % 16) * 256 + d);
  endtask

  task automatic do_read(input logic [7:0] a);
    frame.push_back(8'hBB); frame.push_back(a);
    exp_rd.push_back(a % 16);
    exp_tx.push_back(rd_tab[a % 16]);
  endtask

  task automatic expect_alu(input logic [7:0] f);
    exp_fun.push_back(f % 16);
    exp_tx.push_back(alu_tab[f % 16] % 256);
    exp_tx.push_back(alu_tab[f % 16] / 256);
  endtask

  task automatic do_alu_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
    frame.push_back(8'hCC); frame.push_back(a); frame.push_back(b); frame.push_back(f);
    exp_wr.push_back(0 * 256 + a);
    exp_wr.push_back(1 * 256 + b);
    expect_alu(f);
  endtask

  task automatic do_alu_nop(input logic [7:0] f);
    frame.push_back(8'hDD); frame.push_back(f);
    expect_alu(f);
  endtask

  task automatic do_unknown(input logic [7:0] op);
    frame.push_back(op);
    exp_err++;
  endtask

`ifdef SYS_CTRL_BURST_CMD_EN
  task automatic do_bwr(input logic [7:0] s, input int n, input logic [7:0] d0, input logic [7:0] step);
    logic [7:0] d;
    frame.push_back(8'hEE); frame.push_back(s); frame.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      d = d0 + 8'(i) * step;
      frame.push_back(d);
      exp_wr.push_back(((s + i) % 16) * 256 + d);
    end
  endtask

  task automatic do_brd(input logic [7:0] s, input int n);
    frame.push_back(8'hEF); frame.push_back(s); frame.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back((s + i) % 16);
      exp_tx.push_back(rd_tab[(s + i) % 16]);
    end
  endtask
`endif

  function automatic bit is_opcode(input logic [7:0] b);
`ifdef SYS_CTRL_BURST_CMD_EN
    if (b == 8'hEE || b == 8'hEF) return 1'b1;
`endif
    return (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD);
  endfunction

  initial begin
    int budget;
    int kind;
    logic [7:0] op;

    for (int i = 0; i < 16; i++) begin
      rd_tab[i]  = 8'($urandom);
      alu_tab[i] = 16'($urandom);
    end
    rd_tab[2]  = 8'h91;
    alu_tab[2] = 16'h0200;

    // Reset state
    repeat (3) @(negedge CLK);
    check_eq("rst CLKDIV_EN", CLKDIV_EN, 0);
    check_eq("rst TX_VLD", TX_VLD, 0);
    check_eq("rst RF_WrEn", RF_WrEn, 0);
    check_eq("rst CMD_ERR", CMD_ERR, 0);
    check_eq("rst CLKG_EN", CLKG_EN, 0);
    check_eq("rst RF_Address", RF_Address, 0);
    check_eq("rst TX_DATA", TX_DATA, 0);
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check_eq("CLKDIV_EN after release", CLKDIV_EN, 1);

    // Single write, strobe visible the cycle after the data byte
    do_write(8'h05, 8'h3C);
    send_frame(0);
    check_eq("wr RF_WrEn", RF_WrEn, 1);
    check_eq("wr RF_Address", RF_Address, 5);
    check_eq("wr RF_WrData", RF_WrData, 8'h3C);
    wait_done();
    compare_all("write");

    // Read held off by FIFO_FULL
    force_full = 1'b1;
    do_read(8'h02);
    send_frame(0);
    budget = 20;
    while (!RF_RdData_Valid && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    repeat (3) @(negedge CLK);
    check_eq("rd_bp tx while full", tx_q.size(), 0);
    check_eq("rd_bp TX_DATA held", TX_DATA, 8'h91);
    force_full = 1'b0;
    wait_done();
    compare_all("rd_bp");

    // ALU with operands, plus a stray byte during ALU_WAIT
    alu_hold = 1'b1;
    do_alu_op(8'h10, 8'h20, 8'h02);
    send_frame(0);
    check_eq("alu ALU_EN", ALU_EN, 1);
    check_eq("alu ALU_FUN", ALU_FUN, 2);
    repeat (3) @(negedge CLK);
    check_eq("alu CLKG_EN busy", CLKG_EN, 1);
    do_unknown(8'h55);
    send_frame(0);
    repeat (2) @(negedge CLK);
    alu_hold = 1'b0;
    wait_done();
    check_eq("alu CLKG_EN after", CLKG_EN, 0);
    compare_all("alu");

    // Unknown opcode
    do_unknown(8'h77);
    send_frame(0);
    wait_done();
    compare_all("unknown");

`ifdef SYS_CTRL_BURST_CMD_EN
    do_bwr(8'h0E, 3, 8'h11, 8'h11);
    send_frame(0);
    wait_done();
    compare_all("bwr_wrap");
    do_bwr(8'h05, 0, 8'h00, 8'h00);
    do_write(8'h09, 8'hA5);
    send_frame(0);
    wait_done();
    compare_all("bwr_zero");
    do_brd(8'h0F, 2);
    send_frame(0);
    wait_done();
    compare_all("brd_wrap");
`else
    do_unknown(8'hEE);
    do_unknown(8'hEF);
    send_frame(1);
    wait_done();
    compare_all("burst_off");
`endif

    // Reset in the middle of a write frame
    frame.push_back(8'hAA); frame.push_back(8'h05);
    send_frame(0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check_eq("midrst CLKDIV_EN", CLKDIV_EN, 0);
    check_eq("midrst RF_WrEn", RF_WrEn, 0);
    @(posedge CLK); #1;
    RST = 1'b1;
    do_read(8'h07);
    send_frame(0);
    wait_done();
    compare_all("midrst");

    // Random frames under random backpressure
    bp_rand = 1'b1;
    for (int it = 0; it < 60; it++) begin
`ifdef SYS_CTRL_BURST_CMD_EN
      kind = $urandom_range(0, 6);
`else
      kind = $urandom_range(0, 4);
`endif
      case (kind)
        0: do_write(8'($urandom), 8'($urandom));
        1: do_read(8'($urandom));
        2: do_alu_op(8'($urandom), 8'($urandom), 8'($urandom));
        3: do_alu_nop(8'($urandom));
`ifdef SYS_CTRL_BURST_CMD_EN
        5: do_bwr(8'($urandom), $urandom_range(0, 4), 8'($urandom), 8'($urandom));
        6: do_brd(8'($urandom), $urandom_range(0, 3));
`endif
        default: begin
          op = 8'($urandom);
          while (is_opcode(op)) op = 8'($urandom);
          do_unknown(op);
        end
      endcase
      send_frame(2);
      wait_done();
      compare_all($sformatf("rnd%0d", it));
    end
    bp_rand = 1'b0;

    check_eq("tx_vld while full", full_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
